awg_uart_cmd_engine: RTL and testbench

- Byte-stream consumer and producer on the far side of the UART streaming interface.
- Parses framed host commands arriving on the receive stream and writes or reads the 8-bit waveform sample memory.
- Returns ACK/NAK and read data on the transmit stream.
- Sits between the UART wrapper and the waveform RAM of the arbitrary waveform generator.

---
 rtl/awg_uart_cmd_engine_if.sv | 31 +++
 rtl/awg_uart_cmd_engine.sv | 178 +++++++++++++++++
 tb/tb_awg_uart_cmd_engine.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/awg_uart_cmd_engine_if.sv
// Stream and memory bundle for the AWG UART command engine.
//   rx_*  : byte stream from the UART receiver (engine consumes)
//   tx_*  : byte stream to the UART transmitter (engine produces)
//   mem_* : waveform sample RAM port (engine drives address/write side)
// Modport master is the engine side; modport slave is the UART/RAM side.
interface awg_uart_cmd_engine_if #(
  parameter int ADDR_W = 12
);
  logic [7:0]        rx_data;
  logic              rx_error;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_error;
  logic              tx_valid;
  logic              tx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport master (
    input  rx_data, rx_error, rx_valid, tx_ready, mem_rdata,
    output rx_ready, tx_data, tx_error, tx_valid, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_error, rx_valid, tx_ready, mem_rdata,
    input  rx_ready, tx_data, tx_error, tx_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/awg_uart_cmd_engine.sv
// AWG UART command engine: parses framed host commands
// (SOF, CMD, ADDR_H, ADDR_L, LEN, payload, CSUM) from the rx byte stream,
// writes/reads the 8-bit waveform RAM and answers ACK/NAK (+ read data)
// on the tx byte stream.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : rx/tx byte streams and waveform RAM port (master side)
//   busy       : high whenever the engine is not in IDLE
//   err_count  : saturating count of NAKs sent, rx errors and timeouts
module awg_uart_cmd_engine #(
  parameter int          ADDR_W      = 12,
  parameter logic [7:0]  SOF_BYTE    = 8'hA5,
  parameter int          TIMEOUT_CYC = 5_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  awg_uart_cmd_engine_if.master bus,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam logic [7:0] CMD_WR = 8'h01;
  localparam logic [7:0] CMD_RD = 8'h02;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;
  localparam int         TMO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN, S_PAYLOAD, S_CSUM,
    S_RESP, S_RD_ADDR, S_RD_WAIT, S_RD_SEND
  } state_t;

  state_t            state, state_nx;
  logic [7:0]        cmd;
  logic [7:0]        addr_h;
  logic [7:0]        csum;
  logic [8:0]        cnt;
  logic              rd_pend;
  logic [ADDR_W-1:0] addr;
  logic [TMO_W-1:0]  tmo;
  logic [7:0]        tx_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        resp_byte;

  logic in_frame, rx_fire, rx_good, rx_bad, tx_fire, tmo_hit, csum_ok, nak_sent;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign in_frame = (state == S_CMD) || (state == S_ADDR_H) || (state == S_ADDR_L) ||
                    (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);

  // rx_ready is gated by reset so it reads 0 while reset is held.
  assign bus.rx_ready  = (in_frame || (state == S_IDLE)) && !reset;
  assign bus.tx_valid  = (state == S_RESP) || (state == S_RD_SEND);
  assign bus.tx_data   = tx_data;
  assign bus.tx_error  = 1'b0;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign busy          = (state != S_IDLE);

  assign rx_fire  = bus.rx_valid && bus.rx_ready;
  assign rx_good  = rx_fire && !bus.rx_error;
  assign rx_bad   = rx_fire && bus.rx_error;
  assign tx_fire  = bus.tx_valid && bus.tx_ready;
  assign tmo_hit  = in_frame && !rx_fire && (tmo == TMO_W'(TIMEOUT_CYC - 1));
  assign csum_ok  = (bus.rx_data == csum);
  assign nak_sent = (state == S_RESP) && tx_fire && (tx_data == NAK);

  always_comb begin
    resp_byte = NAK;
    if ((cmd == CMD_WR) || (cmd == CMD_RD))
      resp_byte = csum_ok ? ACK : NAK;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (rx_bad || tmo_hit) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (rx_good && (bus.rx_data == SOF_BYTE)) state_nx = S_CMD;
        S_CMD:     if (rx_good) state_nx = S_ADDR_H;
        S_ADDR_H:  if (rx_good) state_nx = S_ADDR_L;
        S_ADDR_L:  if (rx_good) state_nx = S_LEN;
        S_LEN:     if (rx_good) state_nx = (cmd == CMD_WR) ? S_PAYLOAD : S_CSUM;
        S_PAYLOAD: if (rx_good && (cnt == 9'd1)) state_nx = S_CSUM;
        S_CSUM:    if (rx_good) state_nx = S_RESP;
        S_RESP:    if (tx_fire) state_nx = rd_pend ? S_RD_ADDR : S_IDLE;
        S_RD_ADDR: state_nx = S_RD_WAIT;
        S_RD_WAIT: state_nx = S_RD_SEND;
        S_RD_SEND: if (tx_fire) state_nx = (cnt == 9'd1) ? S_IDLE : S_RD_ADDR;
        default:   state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd       <= '0;
      addr_h    <= '0;
      csum      <= '0;
      cnt       <= '0;
      rd_pend   <= 1'b0;
      addr      <= '0;
      tmo       <= '0;
      tx_data   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err_count <= '0;
    end else begin
      mem_we <= 1'b0;
      // Inter-byte timer only runs while a frame is being received.
      tmo <= (in_frame && !rx_fire && !tmo_hit) ? tmo + 1'b1 : '0;

      if (rx_bad || tmo_hit || nak_sent)
        err_count <= sat_inc(err_count);

      if (rx_good) begin
        case (state)
          S_CMD: begin
            cmd     <= bus.rx_data;
            csum    <= bus.rx_data;
            rd_pend <= 1'b0;
          end
          S_ADDR_H: begin
            addr_h <= bus.rx_data;
            csum   <= csum ^ bus.rx_data;
          end
          S_ADDR_L: begin
            addr <= ADDR_W'({addr_h, bus.rx_data});
            csum <= csum ^ bus.rx_data;
          end
          S_LEN: begin
            cnt  <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
            csum <= csum ^ bus.rx_data;
          end
          S_PAYLOAD: begin
            // Writes commit as they arrive, independent of the final CSUM.
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= bus.rx_data;
            addr      <= addr + 1'b1;
            cnt       <= cnt - 9'd1;
            csum      <= csum ^ bus.rx_data;
          end
          S_CSUM: begin
            tx_data <= resp_byte;
            rd_pend <= (cmd == CMD_RD) && csum_ok;
          end
          default: ;
        endcase
      end

      // mem_addr is set on entry to RD_ADDR so rdata is valid in RD_WAIT.
      if ((state == S_RESP) && tx_fire && rd_pend)
        mem_addr <= addr;
      if (state == S_RD_WAIT)
        tx_data <= bus.mem_rdata;
      if ((state == S_RD_SEND) && tx_fire && (cnt != 9'd1)) begin
        addr     <= addr + 1'b1;
        mem_addr <= addr + 1'b1;
        cnt      <= cnt - 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_awg_uart_cmd_engine.sv
module tb_awg_uart_cmd_engine;

  logic       clk;
  logic       reset;
  logic       busy;
  logic [7:0] err_count;

  int tests = 0;
  int fails = 0;

  awg_uart_cmd_engine_if #(.ADDR_W(12)) bus();

  awg_uart_cmd_engine #(
    .ADDR_W(12), .SOF_BYTE(8'hA5), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model and stream monitors
  logic [7:0]  mem [4096];
  logic [7:0]  tx_q [$];
  logic [11:0] wr_a [$];
  logic [7:0]  wr_d [$];
  int          stab_viol = 0;
  int          rdy_viol  = 0;
  logic        pv, pr;
  logic [7:0]  pd;
  logic [7:0]  frm [$];

  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr];
    if (reset) begin
      pv <= 1'b0;
    end else begin
      if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
      if (bus.mem_we) begin
        mem[bus.mem_addr] <= bus.mem_wdata;
        wr_a.push_back(bus.mem_addr);
        wr_d.push_back(bus.mem_wdata);
      end
      if (pv && !pr && (!bus.tx_valid || bus.tx_data != pd)) stab_viol++;
      if (bus.tx_valid && bus.rx_ready) rdy_viol++;
      pv <= bus.tx_valid;
      pr <= bus.tx_ready;
      pd <= bus.tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic e);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_data = b; bus.rx_valid = 1'b1; bus.rx_error = e;
    while (!bus.rx_ready && n < 1000) begin @(negedge clk); n++; end
    if (!bus.rx_ready) begin
      tests++; fails++;
      $display("FAIL rx_accept: rx_ready=0 after %0d cycles, required 1", n);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.rx_error = 1'b0;
  endtask

  task automatic send_frame();
    foreach (frm[i]) send_byte(frm[i], 1'b0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    @(negedge clk);
    while (busy && n < 3000) begin @(negedge clk); n++; end
    if (busy) begin
      tests++; fails++;
      $display("FAIL wait_idle: busy=1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic test_reset();
    bus.rx_data = 0; bus.rx_valid = 0; bus.rx_error = 0; bus.tx_ready = 1'b1;
    reset = 1'b1;
    #12;
    tests++; if (bus.rx_ready !== 1'b0) begin fails++; $display("FAIL rst_rx_ready: got %b want 0", bus.rx_ready); end
    tests++; if (bus.tx_valid !== 1'b0) begin fails++; $display("FAIL rst_tx_valid: got %b want 0", bus.tx_valid); end
    tests++; if (bus.tx_data !== 8'h00) begin fails++; $display("FAIL rst_tx_data: got %h want 00", bus.tx_data); end
    tests++; if (bus.tx_error !== 1'b0) begin fails++; $display("FAIL rst_tx_error: got %b want 0", bus.tx_error); end
    tests++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== 12'h000 || bus.mem_wdata !== 8'h00) begin
      fails++; $display("FAIL rst_mem: we=%b addr=%h wdata=%h want 0/000/00", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    tests++; if (busy !== 1'b0 || err_count !== 8'd0) begin
      fails++; $display("FAIL rst_status: busy=%b err=%0d want 0/0", busy, err_count); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    tests++; if (bus.rx_ready !== 1'b1) begin fails++; $display("FAIL rst_release_rx_ready: got %b want 1", bus.rx_ready); end
  endtask

  task automatic test_write();
    int n, wb, tb0;
    logic [11:0] ea [3];
    logic [7:0]  ed [3];
    ea = '{12'h010, 12'h011, 12'h012};
    ed = '{8'h11, 8'h22, 8'h33};
    wb = wr_a.size(); tb0 = tx_q.size();
    frm = '{8'hA5, 8'h01, 8'h00, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h12};
    send_frame(); wait_idle(n);
    tests++; if (wr_a.size() - wb != 3) begin fails++; $display("FAIL wr_count: got %0d want 3", wr_a.size() - wb); end
    for (int i = 0; i < 3; i++) if (wr_a.size() > wb + i) begin
      tests++;
      if (wr_a[wb+i] !== ea[i] || wr_d[wb+i] !== ed[i]) begin
        fails++; $display("FAIL wr_%0d: got %h/%h want %h/%h", i, wr_a[wb+i], wr_d[wb+i], ea[i], ed[i]); end
    end
    tests++; if (tx_q.size() - tb0 != 1 || tx_q[tb0] !== 8'h06) begin
      fails++; $display("FAIL wr_ack: got n=%0d first=%h want 1 x 06", tx_q.size() - tb0, tx_q[tb0]); end
  endtask

  task automatic test_read_backpressure();
    int n, tb0, sv0, rv0;
    logic [7:0] exp [4];
    exp = '{8'h06, 8'h11, 8'h22, 8'h33};
    tb0 = tx_q.size(); sv0 = stab_viol; rv0 = rdy_viol;
    frm = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h03, 8'h11};
    send_frame();
    n = 0;
    while (busy && n < 200) begin @(negedge clk); bus.tx_ready = ~bus.tx_ready; n++; end
    bus.tx_ready = 1'b1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_done: busy=%b want 0", busy); end
    tests++; if (tx_q.size() - tb0 != 4) begin fails++; $display("FAIL rd_len: got %0d want 4", tx_q.size() - tb0); end
    for (int i = 0; i < 4; i++) if (tx_q.size() > tb0 + i) begin
      tests++;
      if (tx_q[tb0+i] !== exp[i]) begin fails++; $display("FAIL rd_byte%0d: got %h want %h", i, tx_q[tb0+i], exp[i]); end
    end
    tests++; if (stab_viol != sv0) begin fails++; $display("FAIL tx_stable: violations=%0d want 0", stab_viol - sv0); end
    tests++; if (rdy_viol != rv0) begin fails++; $display("FAIL rx_backpressure: violations=%0d want 0", rdy_viol - rv0); end
  endtask

  task automatic test_bad_csum();
    int n, wb, tb0;
    wb = wr_a.size(); tb0 = tx_q.size();
    frm = '{8'hA5, 8'h01, 8'h00, 8'h20, 8'h01, 8'h44, 8'h00};
    send_frame(); wait_idle(n);
    tests++; if (wr_a.size() - wb != 1 || wr_a[wb] !== 12'h020 || wr_d[wb] !== 8'h44) begin
      fails++; $display("FAIL badcs_write: n=%0d addr=%h data=%h want 1 020/44", wr_a.size() - wb, wr_a[wb], wr_d[wb]); end
    tests++; if (tx_q.size() - tb0 != 1 || tx_q[tb0] !== 8'h15) begin
      fails++; $display("FAIL badcs_nak: n=%0d first=%h want 1 x 15", tx_q.size() - tb0, tx_q[tb0]); end
    tests++; if (err_count !== 8'd1) begin fails++; $display("FAIL badcs_err: got %0d want 1", err_count); end
    tb0 = tx_q.size();
    frm = '{8'hA5, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h7F};
    send_frame(); wait_idle(n);
    tests++; if (tx_q.size() - tb0 != 1 || tx_q[tb0] !== 8'h15) begin
      fails++; $display("FAIL badcmd_nak: n=%0d first=%h want 1 x 15", tx_q.size() - tb0, tx_q[tb0]); end
    tests++; if (err_count !== 8'd2) begin fails++; $display("FAIL badcmd_err: got %0d want 2", err_count); end
  endtask

  task automatic test_wrap();
    int n, tb0, bad;
    logic [7:0] cs;
    // Write AB to 0xFFF and CD to 0x000 in one wrapping frame.
    tb0 = tx_q.size();
    frm = '{8'hA5, 8'h01, 8'h0F, 8'hFF, 8'h02, 8'hAB, 8'hCD, 8'h95};
    send_frame(); wait_idle(n);
    tests++; if (tx_q[tb0] !== 8'h06 || mem[12'hFFF] !== 8'hAB || mem[12'h000] !== 8'hCD) begin
      fails++; $display("FAIL wrap_write: ack=%h fff=%h 000=%h want 06/AB/CD", tx_q[tb0], mem[12'hFFF], mem[12'h000]); end
    tb0 = tx_q.size();
    frm = '{8'hA5, 8'h02, 8'h0F, 8'hFF, 8'h02, 8'hF0};
    send_frame(); wait_idle(n);
    tests++; if (tx_q.size() - tb0 != 3 || tx_q[tb0] !== 8'h06 || tx_q[tb0+1] !== 8'hAB || tx_q[tb0+2] !== 8'hCD) begin
      fails++; $display("FAIL wrap_read: n=%0d bytes=%h %h %h want 06 AB CD", tx_q.size() - tb0, tx_q[tb0], tx_q[tb0+1], tx_q[tb0+2]); end
    // 256-byte write at 0x100 with data i^5A: total XOR of payload is 0, so CS = 01^01 = 00.
    tb0 = tx_q.size();
    frm = '{8'hA5, 8'h01, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 256; i++) frm.push_back(8'(i) ^ 8'h5A);
    frm.push_back(8'h00);
    send_frame(); wait_idle(n);
    tests++; if (tx_q[tb0] !== 8'h06) begin fails++; $display("FAIL len0_write_ack: got %h want 06", tx_q[tb0]); end
    tb0 = tx_q.size();
    cs = 8'h03;
    frm = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, cs};
    send_frame(); wait_idle(n);
    tests++; if (tx_q.size() - tb0 != 257 || tx_q[tb0] !== 8'h06) begin
      fails++; $display("FAIL len0_read_hdr: n=%0d first=%h want 257 / 06", tx_q.size() - tb0, tx_q[tb0]); end
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (tx_q.size() > tb0 + 1 + i && tx_q[tb0+1+i] !== (8'(i) ^ 8'h5A)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL len0_read_data: %0d wrong bytes want 0", bad); end
  endtask

  task automatic test_timeout();
    int n, tb0, wb;
    tb0 = tx_q.size();
    frm = '{8'hA5, 8'h01, 8'h00};
    send_frame();
    repeat (50) @(negedge clk);
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL tmo_early: busy=%b want 1", busy); end
    wait_idle(n);
    tests++; if (n + 50 < 95 || n + 50 > 105) begin fails++; $display("FAIL tmo_len: got %0d cycles want ~100", n + 50); end
    tests++; if (tx_q.size() != tb0) begin fails++; $display("FAIL tmo_tx: got %0d bytes want 0", tx_q.size() - tb0); end
    tests++; if (err_count !== 8'd3) begin fails++; $display("FAIL tmo_err: got %0d want 3", err_count); end
    wb = wr_a.size();
    frm = '{8'hA5, 8'h01, 8'h00, 8'h30, 8'h01, 8'h77, 8'h47};
    send_frame(); wait_idle(n);
    tests++; if (tx_q.size() - tb0 != 1 || tx_q[tb0] !== 8'h06 || wr_a[wb] !== 12'h030 || wr_d[wb] !== 8'h77) begin
      fails++; $display("FAIL tmo_recover: n=%0d ack=%h wr=%h/%h want 1 06 030/77", tx_q.size() - tb0, tx_q[tb0], wr_a[wb], wr_d[wb]); end
    tb0 = tx_q.size();
    frm = '{8'hA5, 8'h01, 8'h00};
    send_frame();
    send_byte(8'h40, 1'b1);
    @(negedge clk);
    tests++; if (busy !== 1'b0 || tx_q.size() != tb0 || err_count !== 8'd4) begin
      fails++; $display("FAIL rxerr_abort: busy=%b tx=%0d err=%0d want 0/0/4", busy, tx_q.size() - tb0, err_count); end
  endtask

  task automatic test_reset_mid_read();
    int n, tb0;
    bus.tx_ready = 1'b0;
    frm = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h01, 8'h13};
    send_frame();
    @(negedge clk); bus.tx_ready = 1'b1;
    @(negedge clk); bus.tx_ready = 1'b0;
    n = 0;
    while (!bus.tx_valid && n < 20) begin @(negedge clk); n++; end
    tests++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h11) begin
      fails++; $display("FAIL mid_read_send: valid=%b data=%h want 1/11", bus.tx_valid, bus.tx_data); end
    reset = 1'b1;
    #1;
    tests++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || err_count !== 8'd0 || bus.tx_data !== 8'h00) begin
      fails++; $display("FAIL mid_read_reset: valid=%b busy=%b err=%0d data=%h want 0/0/0/00", bus.tx_valid, busy, err_count, bus.tx_data); end
    @(negedge clk); reset = 1'b0; bus.tx_ready = 1'b1;
    tb0 = tx_q.size();
    frm = '{8'hA5, 8'h01, 8'h00, 8'h40, 8'h01, 8'h99, 8'hD9};
    send_frame(); wait_idle(n);
    tests++; if (tx_q.size() - tb0 != 1 || tx_q[tb0] !== 8'h06 || mem[12'h040] !== 8'h99) begin
      fails++; $display("FAIL post_reset_write: n=%0d ack=%h mem=%h want 1 06 99", tx_q.size() - tb0, tx_q[tb0], mem[12'h040]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_backpressure();
    test_bad_csum();
    test_wrap();
    test_timeout();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
